write_buffer: RTL and testbench
===============================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of posted-write entries (a power of two, at least 2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, meaning the address width in bits.
REQ-003 SHALL have parameter WORD_WIDTH, default 64, meaning the data word width in bits.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port addr, input, ADDR_WIDTH bits: upstream request address.
REQ-007 SHALL have port din, input, WORD_WIDTH bits: upstream write data.
REQ-008 SHALL have port dout, output reg, WORD_WIDTH bits: read return data.
REQ-009 SHALL have ports re and we, inputs, 1 bit each: upstream read and write strobes.
REQ-010 SHALL have port ready, output, 1 bit: upstream may issue; read data is valid.
REQ-011 SHALL have ports maddr (ADDR_WIDTH), mout (WORD_WIDTH), mre (1) and mwe (1), outputs: downstream memory request.
REQ-012 SHALL have ports min (WORD_WIDTH) and mready (1), inputs: downstream read data and completion.

Function
REQ-013 SHALL accept a request on a rising edge where ready=1 and (re|we)=1; re takes priority if both are high.
REQ-014 SHALL combinationally drive ready = !full && !rd_busy, where rd_busy is set when a read is accepted.
REQ-015 SHALL push an accepted write {addr,din} into a FIFO of DEPTH entries; the write completes upstream with zero stall.
REQ-016 SHALL track occupancy in a count register of width clog2(DEPTH)+1; head and tail pointers wrap modulo DEPTH.
REQ-017 SHALL drain with states IDLE, ISSUE and WAIT; in IDLE with the FIFO non-empty it goes to ISSUE.
REQ-018 SHALL in ISSUE drive maddr/mout from the head entry and pulse mwe for exactly one cycle, then go to WAIT.
REQ-019 SHALL in WAIT ignore mready on the first WAIT cycle, then on mready=1 pop the head and return to IDLE.
REQ-020 SHALL permit a push and a pop in the same cycle, leaving count unchanged.
REQ-021 SHALL never push when full (ready=0), and SHALL never pop when empty.
REQ-022 SHALL, for a read miss, wait until the FIFO is empty and the state is IDLE, then issue maddr=addr with a one-cycle mre pulse (same ISSUE/WAIT timing as writes).
REQ-023 SHALL on read completion load dout<=min, clear rd_busy, and thereby raise ready; dout is valid while ready=1 after that read.
REQ-024 SHALL latch the read address at acceptance; addr may change while rd_busy=1.
REQ-025 SHALL never assert mre and mwe in the same cycle; each is high for at most one cycle per transaction.
REQ-026 SHALL leave dout unchanged on writes.

Reset
REQ-027 SHALL, when rst=0 at a rising edge, clear count, head, tail and rd_busy, set the state to IDLE, and drive mre=0, mwe=0, dout=0, maddr=0 and mout=0.
REQ-028 SHALL discard buffered writes and any in-flight transaction when reset is asserted mid-operation; ready=1 on the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with WRITE_BUFFER_FORWARD_EN defined, compare an accepted read address against all valid entries.
REQ-030 SHALL, on a forwarding match, load dout with the data of the youngest matching entry one cycle after acceptance, with ready low for exactly that one cycle and no mre issued.
REQ-031 SHALL, with WRITE_BUFFER_FORWARD_EN undefined, treat every read as a miss per REQ-022 and include no comparators.

Verification
REQ-032 Bench: reset, then write 0x10<-0xAA; expect ready held at 1, mwe pulse 1 cycle later with maddr=0x10 and mout=0xAA, and count back at 0 after mready.
REQ-033 Bench: DEPTH=4 with mready held 0, issue 5 back-to-back writes; expect ready=0 after the 4th and the 5th not accepted until the first pop.
REQ-034 Bench: write 0x20<-0x1, write 0x20<-0x2, read 0x20; with FORWARD_EN expect dout=0x2 after 1 cycle and no mre; without it expect two mwe pulses before one mre, then dout=min.
REQ-035 Bench: read miss 0x30 with min=0xBEEF and mready low for 3 cycles; expect ready=0 throughout and dout=0xBEEF when ready rises.
REQ-036 Bench: assert rst=0 during WAIT with 3 entries buffered; expect count=0, mre=mwe=0, dout=0 and no further mwe after release.
REQ-037 Bench: push while a pop completes at count=2; expect count=2 and pointers wrapped correctly after 8 total writes.

Source files
------------

// File: rtl/write_buffer_if.sv
// Upstream request/response and downstream memory signals of the posted-write buffer.
// The buffer takes the slave view; whoever drives requests and models memory takes the master view.
interface write_buffer_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] din;
    logic [WORD_WIDTH-1:0] dout;
    logic                  re;
    logic                  we;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] maddr;
    logic [WORD_WIDTH-1:0] mout;
    logic                  mre;
    logic                  mwe;
    logic [WORD_WIDTH-1:0] min;
    logic                  mready;

    modport master (
        output addr, din, re, we, min, mready,
        input  dout, ready, maddr, mout, mre, mwe
    );

    modport slave (
        input  addr, din, re, we, min, mready,
        output dout, ready, maddr, mout, mre, mwe
    );
endinterface

// File: rtl/write_buffer.sv
// Posted-write buffer: writes are queued and drained one at a time; reads wait for the queue to empty.
// Define WRITE_BUFFER_FORWARD_EN to serve reads that hit a buffered write straight from the queue.
module write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    write_buffer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      count_reg;
    logic [PTR_W-1:0]      head_reg, tail_reg;
    logic                  rd_busy_reg;
    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic                  cur_read_reg;
    logic                  wait_first_reg;
    logic [ADDR_WIDTH-1:0] maddr_reg;
    logic [WORD_WIDTH-1:0] mout_reg;
    logic                  mwe_reg, mre_reg;
    logic [WORD_WIDTH-1:0] dout_reg;

    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [WORD_WIDTH-1:0] mem_data [DEPTH];

    logic full, empty, ready;
    logic accept_rd, accept_wr;
    logic issue_wr, issue_rd, pop, rd_done;
    logic fwd_pending;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign ready     = !full && !rd_busy_reg;
    assign accept_rd = ready && bus.re;
    assign accept_wr = ready && bus.we && !bus.re;

    assign bus.ready = ready;
    assign bus.maddr = maddr_reg;
    assign bus.mout  = mout_reg;
    assign bus.mwe   = mwe_reg;
    assign bus.mre   = mre_reg;
    assign bus.dout  = dout_reg;

`ifdef WRITE_BUFFER_FORWARD_EN
    logic                  fwd_pending_reg;
    logic [WORD_WIDTH-1:0] fwd_data_reg;
    logic [DEPTH-1:0]      addr_match;
    logic                  fwd_hit;
    logic [WORD_WIDTH-1:0] fwd_sel;
    logic [PTR_W-1:0]      fwd_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign addr_match[gi] = (mem_addr[gi] == bus.addr);
        end
    endgenerate

    // Walk entries oldest to youngest so the last valid match wins.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_sel = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_reg + PTR_W'(k);
            if ((CNT_W'(k) < count_reg) && addr_match[fwd_idx]) begin
                fwd_hit = 1'b1;
                fwd_sel = mem_data[fwd_idx];
            end
        end
    end

    assign fwd_pending = fwd_pending_reg;
`else
    assign fwd_pending = 1'b0;
`endif

    // Buffered writes always drain before a pending read miss is issued.
    always_comb begin
        state_next = state_reg;
        issue_wr   = 1'b0;
        issue_rd   = 1'b0;
        pop        = 1'b0;
        rd_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    issue_wr   = 1'b1;
                    state_next = ISSUE;
                end else if (rd_busy_reg && !fwd_pending) begin
                    issue_rd   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (!wait_first_reg && bus.mready) begin
                    state_next = IDLE;
                    if (cur_read_reg) rd_done = 1'b1;
                    else              pop     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem_addr[tail_reg] <= bus.addr;
            mem_data[tail_reg] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            head_reg       <= '0;
            tail_reg       <= '0;
            rd_busy_reg    <= 1'b0;
            rd_addr_reg    <= '0;
            cur_read_reg   <= 1'b0;
            wait_first_reg <= 1'b0;
            maddr_reg      <= '0;
            mout_reg       <= '0;
            mwe_reg        <= 1'b0;
            mre_reg        <= 1'b0;
            dout_reg       <= '0;
`ifdef WRITE_BUFFER_FORWARD_EN
            fwd_pending_reg <= 1'b0;
            fwd_data_reg    <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            mwe_reg        <= issue_wr;
            mre_reg        <= issue_rd;
            wait_first_reg <= (state_reg == ISSUE);
            if (issue_wr) begin
                maddr_reg    <= mem_addr[head_reg];
                mout_reg     <= mem_data[head_reg];
                cur_read_reg <= 1'b0;
            end
            if (issue_rd) begin
                maddr_reg    <= rd_addr_reg;
                cur_read_reg <= 1'b1;
            end
            if (accept_wr) tail_reg <= tail_reg + PTR_W'(1);
            if (pop)       head_reg <= head_reg + PTR_W'(1);
            case ({accept_wr, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (accept_rd) begin
                rd_busy_reg <= 1'b1;
                rd_addr_reg <= bus.addr;
            end
            if (rd_done) begin
                dout_reg    <= bus.min;
                rd_busy_reg <= 1'b0;
            end
`ifdef WRITE_BUFFER_FORWARD_EN
            if (accept_rd && fwd_hit) begin
                fwd_pending_reg <= 1'b1;
                fwd_data_reg    <= fwd_sel;
            end
            if (fwd_pending_reg) begin
                dout_reg        <= fwd_data_reg;
                rd_busy_reg     <= 1'b0;
                fwd_pending_reg <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: stimulus pushes expected memory requests and read data into
// queues; a negedge monitor pops and compares whenever the buffer presents them.
module tb_write_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    write_buffer_if #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) bus();

    write_buffer #(.DEPTH(4), .ADDR_WIDTH(64), .WORD_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        is_rd;
        logic [63:0] a;
        logic [63:0] d;
    } exp_t;

    exp_t        mq[$];
    logic [63:0] dq[$];
    int          total = 0;
    int          bad   = 0;

    // Memory model: answers each request after resp_delay negedges, holding mready for two cycles.
    int          resp_delay = 1;
    int          delay_cnt  = 0;
    int          hold_cnt   = 0;
    bit          mem_stall  = 1'b0;
    bit          mem_manual = 1'b0;
    logic        man_rdy    = 1'b0;
    logic        resp_rdy   = 1'b0;
    logic [63:0] mem_rdata  = 64'h0;

    assign bus.mready = mem_manual ? man_rdy : resp_rdy;
    assign bus.min    = mem_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                delay_cnt = 0;
                hold_cnt  = 0;
                resp_rdy  = 1'b0;
            end else begin
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) resp_rdy = 1'b0;
                end
                if (delay_cnt > 0 && !mem_stall) begin
                    delay_cnt--;
                    if (delay_cnt == 0) begin
                        resp_rdy = 1'b1;
                        hold_cnt = 2;
                    end
                end
                if ((bus.mwe || bus.mre) && !mem_manual) delay_cnt = resp_delay;
            end
        end
    end

    // Monitor
    logic prev_mwe = 1'b0, prev_mre = 1'b0, prev_ready = 1'b1;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_mwe   = 1'b0;
                prev_mre   = 1'b0;
                prev_ready = 1'b1;
            end else begin
                if (bus.mwe || bus.mre) begin
                    chk("mre_mwe_exclusive", 64'(bus.mwe & bus.mre), 64'h0);
                    chk("pulse_one_cycle", 64'((bus.mwe & prev_mwe) | (bus.mre & prev_mre)), 64'h0);
                    if (mq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: got mwe=%b mre=%b maddr=%0h want no request",
                                 bus.mwe, bus.mre, bus.maddr);
                    end else begin
                        e = mq.pop_front();
                        chk("req_kind_mre", 64'(bus.mre), 64'(e.is_rd));
                        chk("maddr", bus.maddr, e.a);
                        if (!e.is_rd) chk("mout", bus.mout, e.d);
                    end
                end
                if (!prev_ready && bus.ready && dq.size() > 0) chk("dout", bus.dout, dq.pop_front());
                prev_mwe   = bus.mwe;
                prev_mre   = bus.mre;
                prev_ready = bus.ready;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with we dropped.
    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        int n = 0;
        bus.we   = 1'b1;
        bus.re   = 1'b0;
        bus.addr = a;
        bus.din  = d;
        while (!bus.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            total++;
            bad++;
            $display("FAIL wr_timeout: got ready=0 want ready=1 within 40 cycles (addr %0h)", a);
        end else begin
            @(posedge clk);
            mq.push_back('{1'b0, a, d});
            @(negedge clk);
        end
        bus.we = 1'b0;
    endtask

    // Issues a read and counts how many negedges ready stays low afterwards.
    task automatic rd(input logic [63:0] a, input logic [63:0] exp, input bit is_fwd, output int low);
        int n = 0;
        low    = 0;
        bus.re   = 1'b1;
        bus.we   = 1'b0;
        bus.addr = a;
        while (!bus.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            total++;
            bad++;
            $display("FAIL rd_timeout: got ready=0 want ready=1 before read of %0h", a);
            bus.re = 1'b0;
        end else begin
            @(posedge clk);
            dq.push_back(exp);
            if (!is_fwd) mq.push_back('{1'b1, a, 64'h0});
            @(negedge clk);
            bus.re   = 1'b0;
            bus.addr = 64'hDEAD_0000;
            while (!bus.ready && low < 60) begin
                low++;
                @(negedge clk);
            end
            if (!bus.ready) begin
                total++;
                bad++;
                $display("FAIL rd_done_timeout: got ready=0 want ready=1 after read of %0h", a);
            end
        end
    endtask

    initial begin
        int low;
        bus.re   = 1'b0;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.din  = '0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("rst_ready", 64'(bus.ready), 64'h1);
        chk("rst_mwe", 64'(bus.mwe), 64'h0);
        chk("rst_mre", 64'(bus.mre), 64'h0);
        chk("rst_dout", bus.dout, 64'h0);
        chk("rst_maddr", bus.maddr, 64'h0);
        chk("rst_mout", bus.mout, 64'h0);
        chk("rst_count", 64'(dut.count_reg), 64'h0);

        // Single posted write
        wr(64'h10, 64'hAA);
        chk("wr_no_stall_ready", 64'(bus.ready), 64'h1);
        @(negedge clk);
        chk("mwe_one_cycle_later", 64'(bus.mwe), 64'h1);
        repeat (10) @(negedge clk);
        chk("single_count", 64'(dut.count_reg), 64'h0);
        chk("single_drained", 64'(mq.size()), 64'h0);

        // Fill with memory stalled
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) wr(64'h100 + 64'(i * 8), 64'h1000 + 64'(i));
        chk("full_ready_low", 64'(bus.ready), 64'h0);
        chk("full_count", 64'(dut.count_reg), 64'h4);
        bus.we = 1'b1;
        bus.addr = 64'h120;
        bus.din = 64'h1004;
        repeat (3) begin
            @(negedge clk);
            chk("full_stall_ready", 64'(bus.ready), 64'h0);
        end
        mem_stall = 1'b0;
        wr(64'h120, 64'h1004);
        chk("fifth_after_pop_count", 64'(dut.count_reg), 64'h4);
        repeat (40) @(negedge clk);
        chk("fill_drained_count", 64'(dut.count_reg), 64'h0);
        chk("fill_drained_q", 64'(mq.size()), 64'h0);

        // Same-address writes followed by a read
        mem_rdata = 64'h5555;
        wr(64'h20, 64'h1);
        wr(64'h20, 64'h2);
`ifdef WRITE_BUFFER_FORWARD_EN
        rd(64'h20, 64'h2, 1'b1, low);
        chk("fwd_ready_low_cycles", 64'(low), 64'h1);
`else
        rd(64'h20, 64'h5555, 1'b0, low);
`endif
        repeat (20) @(negedge clk);
        chk("raw_drained_q", 64'(mq.size()), 64'h0);
        chk("raw_dq_empty", 64'(dq.size()), 64'h0);

        // Read miss with slow memory
        resp_delay = 4;
        mem_rdata  = 64'hBEEF;
        rd(64'h30, 64'hBEEF, 1'b0, low);
        chk("miss_ready_low_cycles", 64'(low), 64'h6);
        chk("miss_dout_hold", bus.dout, 64'hBEEF);
        resp_delay = 1;

        // Reset in the middle of a stalled drain
        mem_stall = 1'b1;
        wr(64'h40, 64'h4A);
        wr(64'h48, 64'h4B);
        wr(64'h50, 64'h4C);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        dq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("midrst_count", 64'(dut.count_reg), 64'h0);
        chk("midrst_mwe", 64'(bus.mwe), 64'h0);
        chk("midrst_mre", 64'(bus.mre), 64'h0);
        chk("midrst_dout", bus.dout, 64'h0);
        chk("midrst_ready", 64'(bus.ready), 64'h1);
        mem_stall = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_still_empty", 64'(dut.count_reg), 64'h0);

        // Push coinciding with pop at count=2, then wrap pointers
        mem_manual = 1'b1;
        man_rdy    = 1'b0;
        wr(64'h60, 64'h60A);
        wr(64'h68, 64'h68B);
        repeat (3) @(negedge clk);
        chk("pp_count_before", 64'(dut.count_reg), 64'h2);
        man_rdy = 1'b1;
        wr(64'h70, 64'h70C);
        man_rdy = 1'b0;
        chk("pp_count_same", 64'(dut.count_reg), 64'h2);
        mem_manual = 1'b0;
        for (int i = 0; i < 5; i++) wr(64'h78 + 64'(i * 8), 64'h780 + 64'(i));
        repeat (50) @(negedge clk);
        chk("wrap_count", 64'(dut.count_reg), 64'h0);
        chk("wrap_head", 64'(dut.head_reg), 64'h0);
        chk("wrap_tail", 64'(dut.tail_reg), 64'h0);
        chk("wrap_drained_q", 64'(mq.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
